// File: rtl/mem_rd_seq_if.sv
// ---------------------------------------------------------------------------
// mem_rd_seq_if
//
// This interface bundles the command handshake, the per-row memory read
// port and the skewed data output of mem_rd_seq. The clock and the reset
// are kept outside the bundle.
//
// Signals:
//   cmd_valid  : command request
//   cmd_ready  : the sequencer can accept a command (IDLE only)
//   cmd_base   : start address of the burst
//   cmd_len    : words per row minus one
//   rd_en      : per-row read enable to the memory array
//   rd_addr    : per-row read address
//   rd_data    : per-row read data (1-cycle memory latency)
//   out_valid  : per-row data valid toward the systolic array
//   out_data   : per-row skewed data
//   busy       : the sequencer is not IDLE
//   done       : one-cycle completion pulse
//
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (command source plus memory array)
// ---------------------------------------------------------------------------
interface mem_rd_seq_if #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [SYS_ROW-1:0]    rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr  [0:SYS_ROW-1];
    logic [DATA_WIDTH-1:0] rd_data  [0:SYS_ROW-1];
    logic [SYS_ROW-1:0]    out_valid;
    logic [DATA_WIDTH-1:0] out_data [0:SYS_ROW-1];
    logic                  busy;
    logic                  done;

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, rd_data,
        output cmd_ready, rd_en, rd_addr, out_valid, out_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_base, cmd_len, rd_data,
        input  cmd_ready, rd_en, rd_addr, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/mem_rd_seq.sv
// ---------------------------------------------------------------------------
// mem_rd_seq
//
// This block is a skewed burst read sequencer that feeds a systolic array.
// Each accepted command (base, len) reads len+1 consecutive words from each
// of SYS_ROW memory rows. Row i starts i cycles after row 0. The read data
// comes back one cycle after the read. It is then presented on out_data[i]
// with out_valid[i] as the diagonal wavefront the array expects.
//
// Timeline (the accept cycle is cycle 0):
//   cycle 1        : RUN, t = 0
//   rd_en[i]       : cycles 1+i .. 1+i+len, rd_addr[i] = base + t - i
//   out_valid[i]   : cycles 2+i .. 2+i+len
//   cycle 1+R+len  : DRAIN, done pulse (R = SYS_ROW)
//   cycle 2+R+len  : IDLE, the next command can be accepted
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_rd_seq_if.slave (command, memory read port, skewed output)
// ---------------------------------------------------------------------------
module mem_rd_seq #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_rd_seq_if.slave  bus
);

    // The step counter must hold len + SYS_ROW - 1 for the largest len.
    // The row comparisons use i + len, so the counter needs the same range.
    localparam int CNT_W = $clog2((1 << ADDR_WIDTH) + SYS_ROW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_t;
    logic [CNT_W-1:0]      w_t_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [ADDR_WIDTH-1:0] w_len_nxt;
    logic [SYS_ROW-1:0]    r_rd_en;
    logic [SYS_ROW-1:0]    w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr     [0:SYS_ROW-1];
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt [0:SYS_ROW-1];
    logic [SYS_ROW-1:0]    r_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data    [0:SYS_ROW-1];
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_last_step;

    // cmd_ready is gated by rst so that a command held during reset is
    // never accepted.
    assign w_cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_last_step = (r_t == (CNT_W'(r_len) + CNT_W'(SYS_ROW - 1)));

    // Next-state logic and next values for the command and step counter.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_base_nxt  = r_base;
        w_len_nxt   = r_len;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                    w_t_nxt     = '0;
                    w_base_nxt  = bus.cmd_base;
                    w_len_nxt   = bus.cmd_len;
                end
            end
            S_RUN: begin
                if (w_last_step) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_t_nxt = r_t + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The read strobes are registered. They are computed from the
    // next-cycle step value, so rd_en[i] is high exactly while
    // i <= t <= i+len in the cycle where that t is current. The output
    // data is gated by out_valid.
    always_comb begin
        w_rd_en_nxt   = '0;
        w_rd_addr_nxt = '{default: '0};
        w_out_data    = '{default: '0};
        for (int unsigned i = 0; i < SYS_ROW; i++) begin
            w_rd_en_nxt[i] = (w_state_nxt == S_RUN)
                          && (w_t_nxt >= CNT_W'(i))
                          && (w_t_nxt <= (CNT_W'(i) + CNT_W'(w_len_nxt)));
            if (w_rd_en_nxt[i]) begin
                // The address wraps modulo 2^ADDR_WIDTH on purpose.
                w_rd_addr_nxt[i] = w_base_nxt + ADDR_WIDTH'(w_t_nxt) - ADDR_WIDTH'(i);
            end
            if (r_out_valid[i]) begin
                w_out_data[i] = bus.rd_data[i];
            end
        end
    end

    // A reset mid-burst clears out_valid as well. Data that returns from
    // reads already issued is therefore never marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_rd_en     <= '0;
            r_rd_addr   <= '{default: '0};
            r_out_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_base      <= w_base_nxt;
            r_len       <= w_len_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_out_valid <= r_rd_en;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DRAIN);

endmodule

// File: tb/tb_mem_rd_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_seq
//
// This bench checks mem_rd_seq against the cycle timing of a skewed burst.
// A memory model returns word[a] = a + 256*row one cycle after each read.
// A negedge monitor checks every output on every cycle. The expected
// out_data stream is a scoreboard queue that is filled when a command is
// accepted and drained as out_valid appears.
// ---------------------------------------------------------------------------
module tb_mem_rd_seq;
    localparam int SYS_ROW    = 16;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rd_seq_if #(.SYS_ROW(SYS_ROW), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_rd_seq #(.SYS_ROW(SYS_ROW), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model with a 1-cycle read latency. A row that is not read
    // returns junk, so ungated output data shows up in the checks.
    function automatic logic [15:0] mem_word(input int row, input logic [7:0] a);
        return 16'(row * 256) + 16'(a);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < SYS_ROW; i++) begin
            bus.rd_data[i] <= bus.rd_en[i] ? mem_word(i, bus.rd_addr[i]) : (16'hA5A5 ^ 16'(i));
        end
    end

    // Scoreboard and monitor state.
    typedef struct {
        int          row;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q[$];

    bit                 chk_en     = 0;
    bit                 mon_active = 0;
    int                 rel        = 0;
    int                 m_base     = 0;
    int                 m_len      = 0;
    int                 done_rel   = 0;
    int                 total_reads = 0;
    int                 cmds_done  = 0;
    int                 n_accepts  = 0;
    int                 n_aborts   = 0;
    int                 cyc        = 0;
    int                 acc_prev   = 0;
    int                 acc_last   = 0;
    int                 hits [SYS_ROW][256];
    logic [SYS_ROW-1:0] en_exp;
    logic [SYS_ROW-1:0] ov_exp;
    logic [7:0]         addr_or;
    logic [15:0]        data_or;
    sb_t                sb_e;
    int                 mism;

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            if (mon_active) begin
                rel++;
                for (int i = 0; i < SYS_ROW; i++) begin
                    en_exp[i] = (rel >= 1 + i) && (rel <= 1 + i + m_len);
                    ov_exp[i] = (rel >= 2 + i) && (rel <= 2 + i + m_len);
                end
                chk("rd_en", 32'(bus.rd_en), 32'(en_exp));
                chk("out_valid", 32'(bus.out_valid), 32'(ov_exp));
                for (int i = 0; i < SYS_ROW; i++) begin
                    if (en_exp[i]) chk("rd_addr", 32'(bus.rd_addr[i]), 32'((m_base + rel - 1 - i) % 256));
                    else           chk("rd_addr_off", 32'(bus.rd_addr[i]), 32'd0);
                    if (bus.rd_en[i]) begin
                        total_reads++;
                        hits[i][bus.rd_addr[i]]++;
                    end
                end
                for (int i = 0; i < SYS_ROW; i++) begin
                    if (bus.out_valid[i]) begin
                        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            sb_e = sb_q.pop_front();
                            chk("out_row", 32'(i), 32'(sb_e.row));
                            chk("out_data", 32'(bus.out_data[i]), 32'(sb_e.data));
                        end
                    end else begin
                        chk("out_data_off", 32'(bus.out_data[i]), 32'd0);
                    end
                end
                chk("done", 32'(bus.done), 32'(rel == SYS_ROW + 1 + m_len));
                if (bus.done) done_rel = rel;
                chk("busy_run", 32'(bus.busy), 32'd1);
                chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
                if (rst) begin
                    mon_active = 0;
                    sb_q.delete();
                    n_aborts++;
                end else if (rel == SYS_ROW + 1 + m_len) begin
                    chk("sb_drained", 32'(sb_q.size()), 32'd0);
                    mism = 0;
                    for (int r = 0; r < SYS_ROW; r++) begin
                        for (int a = 0; a < 256; a++) begin
                            if (hits[r][a] != (((a - m_base + 256) % 256) <= m_len ? 1 : 0)) mism++;
                        end
                    end
                    chk("read_map", 32'(mism), 32'd0);
                    mon_active = 0;
                    cmds_done++;
                end
            end else begin
                addr_or = '0;
                data_or = '0;
                for (int i = 0; i < SYS_ROW; i++) begin
                    addr_or |= bus.rd_addr[i];
                    data_or |= bus.out_data[i];
                end
                chk("rd_en_idle", 32'(bus.rd_en), 32'd0);
                chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
                chk("rd_addr_idle", 32'(addr_or), 32'd0);
                chk("out_data_idle", 32'(data_or), 32'd0);
                chk("done_idle", 32'(bus.done), 32'd0);
                chk("busy_idle", 32'(bus.busy), 32'd0);
                chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'(!rst));
                if (!rst && bus.cmd_valid && bus.cmd_ready) begin
                    mon_active  = 1;
                    rel         = 0;
                    m_base      = int'(bus.cmd_base);
                    m_len       = int'(bus.cmd_len);
                    done_rel    = 0;
                    total_reads = 0;
                    n_accepts++;
                    acc_prev = acc_last;
                    acc_last = cyc;
                    for (int r = 0; r < SYS_ROW; r++)
                        for (int a = 0; a < 256; a++) hits[r][a] = 0;
                    // Expected arrivals in (step, row) order. This is the
                    // same order in which the monitor pops them.
                    for (int c = 0; c <= m_len + SYS_ROW - 1; c++) begin
                        for (int i = 0; i < SYS_ROW; i++) begin
                            if (c >= i && c <= i + m_len) begin
                                sb_e.row  = i;
                                sb_e.data = 16'(i * 256 + (m_base + c - i) % 256);
                                sb_q.push_back(sb_e);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] b, input logic [7:0] l, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = b;
        bus.cmd_len   = l;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus.cmd_ready && !rst) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && cmds_done < target; k++) @(negedge clk);
        chk("burst_complete", 32'(cmds_done), 32'(target));
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        int         exp_done;
        int         exp_reads;
    } vec_t;
    vec_t vt[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int prev;
        int acc0;

        vt[0] = '{base: 8'h10, len: 8'd3,   exp_done: 20,  exp_reads: 64};
        vt[1] = '{base: 8'hFE, len: 8'd3,   exp_done: 20,  exp_reads: 64};
        vt[2] = '{base: 8'h00, len: 8'd0,   exp_done: 17,  exp_reads: 16};
        vt[3] = '{base: 8'hF0, len: 8'd255, exp_done: 272, exp_reads: 4096};
        vt[4] = '{base: 8'h7C, len: 8'd20,  exp_done: 37,  exp_reads: 336};

        // Reset for two cycles while a command is offered.
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = 8'h55;
        bus.cmd_len   = 8'd3;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy_after", 32'(bus.busy), 32'd0);
        chk("rst_no_accept", 32'(n_accepts), 32'd0);

        // Abort: rst is high during cycle 5 of a len=7 burst.
        prev = cmds_done;
        issue(8'h30, 8'd7, ok);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(cmds_done), 32'(prev));
        chk("abort_seen", 32'(n_aborts), 32'd1);

        // Table of single bursts.
        for (int v = 0; v < 5; v++) begin
            prev = cmds_done;
            issue(vt[v].base, vt[v].len, ok);
            if (ok) begin
                wait_done(prev + 1, 400);
                chk("done_cycle", 32'(done_rel), 32'(vt[v].exp_done));
                chk("total_reads", 32'(total_reads), 32'(vt[v].exp_reads));
            end
        end

        // Back-to-back: cmd_valid is held high across two commands.
        prev = cmds_done;
        acc0 = n_accepts;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = 8'h20;
        bus.cmd_len   = 8'd2;
        for (int k = 0; k < 50 && n_accepts == acc0; k++) @(negedge clk);
        chk("b2b_first_accept", 32'(n_accepts), 32'(acc0 + 1));
        @(posedge clk); #1;
        bus.cmd_base = 8'h40;
        bus.cmd_len  = 8'd5;
        for (int k = 0; k < 100 && n_accepts < acc0 + 2; k++) @(negedge clk);
        chk("b2b_second_accept", 32'(n_accepts), 32'(acc0 + 2));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("b2b_gap", 32'(acc_last - acc_prev), 32'd20);
        wait_done(prev + 2, 200);
        chk("b2b_done_cycle", 32'(done_rel), 32'd22);
        chk("b2b_reads", 32'(total_reads), 32'd96);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
